// File: rtl/r5fp_arb_pkg.sv
// r5fp_arb_pkg: shared FSM state encoding and id-width helper for the divide/sqrt arbiter
package r5fp_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;
  function automatic int id_width(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/r5fp_rr_arb.sv
// r5fp_rr_arb: round-robin one-hot grant over req, searching from the index after ptr
module r5fp_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IDW   = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx
);
  logic [IDW-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IDW'((int'(ptr) + k) % N_REQ);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/r5fp_divsqrt_arb.sv
// r5fp_divsqrt_arb: round-robin arbiter sharing one integer divide/sqrt unit among N_REQ requesters
module r5fp_divsqrt_arb
  import r5fp_arb_pkg::*;
#(
  parameter int W     = 26,
  parameter int N_REQ = 2,
  localparam int IDW  = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ*W-1:0] req_N_i,
  input  logic [N_REQ*W-1:0] req_D_i,
  input  logic [N_REQ-1:0]   req_is_div_i,
  input  logic               flush_i,
  output logic [W-1:0]       unit_N_o,
  output logic [W-1:0]       unit_D_o,
  output logic               unit_is_div_o,
  output logic               unit_strobe_o,
  input  logic [W-1:0]       unit_Quo_i,
  input  logic [W-1:0]       unit_Rem_i,
  input  logic               unit_done_i,
  input  logic               unit_ready_i,
  output logic [N_REQ-1:0]   rsp_valid_o,
  input  logic [N_REQ-1:0]   rsp_ready_i,
  output logic [W-1:0]       rsp_Quo_o,
  output logic [W-1:0]       rsp_Rem_o,
  output logic [IDW-1:0]     rsp_id_o,
  output logic               busy_o
);
  arb_state_e state, state_nxt;
  logic [IDW-1:0] ptr, gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic grant, rsp_fire;
  r5fp_rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_rr (
    .req(req_valid_i),
    .ptr(ptr),
    .gnt(gnt),
    .idx(gnt_idx)
  );
  always_comb begin
    grant         = state == IDLE && unit_ready_i && !flush_i && |req_valid_i;
    rsp_fire      = state == RESP && rsp_ready_i[rsp_id_o];
    req_ready_o   = grant ? gnt : '0;
    rsp_valid_o   = state == RESP ? N_REQ'(1) << rsp_id_o : '0;
    unit_strobe_o = state == ISSUE;
    busy_o        = state != IDLE;
    state_nxt     = flush_i ? IDLE
                  : state == IDLE  ? (grant ? ISSUE : IDLE)
                  : state == ISSUE ? BUSY
                  : state == BUSY  ? (unit_done_i ? RESP : BUSY)
                  : (rsp_fire ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= IDW'(N_REQ - 1);
      unit_N_o      <= '0;
      unit_D_o      <= '0;
      unit_is_div_o <= 1'b0;
      rsp_id_o      <= '0;
      rsp_Quo_o     <= '0;
      rsp_Rem_o     <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ptr           <= gnt_idx;
        rsp_id_o      <= gnt_idx;
        unit_N_o      <= req_N_i[gnt_idx*W +: W];
        unit_D_o      <= req_D_i[gnt_idx*W +: W];
        unit_is_div_o <= req_is_div_i[gnt_idx];
      end
      if (state == BUSY && unit_done_i && !flush_i) begin
        rsp_Quo_o <= unit_Quo_i;
        rsp_Rem_o <= unit_Rem_i;
      end
    end
  end
endmodule

// File: tb/tb_r5fp_divsqrt_arb.sv
// tb_r5fp_divsqrt_arb: directed and randomized checks of the divide/sqrt arbiter against a behavioural model
module tb_r5fp_divsqrt_arb;
  localparam int W = 26;
  localparam int N = 2;
  localparam int IDW = 1;
  localparam int L = 14;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid_i, req_ready_o, req_is_div_i, rsp_valid_o, rsp_ready_i;
  logic [N*W-1:0] req_N_i, req_D_i;
  logic flush_i, unit_is_div_o, unit_strobe_o, unit_done_i, unit_ready_i, busy_o;
  logic [W-1:0] unit_N_o, unit_D_o, unit_Quo_i, unit_Rem_i, rsp_Quo_o, rsp_Rem_o;
  logic [IDW-1:0] rsp_id_o;
  logic [W-1:0] n_arr[N];
  logic [W-1:0] d_arr[N];
  logic div_arr[N];
  logic u_busy, force_rdy;
  int u_cnt;
  logic [W-1:0] u_q, u_r;
  int n_cmp = 0;
  int n_bad = 0;
  int last_g;
  r5fp_divsqrt_arb #(.W(W), .N_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_N_i(req_N_i), .req_D_i(req_D_i), .req_is_div_i(req_is_div_i),
    .flush_i(flush_i),
    .unit_N_o(unit_N_o), .unit_D_o(unit_D_o), .unit_is_div_o(unit_is_div_o),
    .unit_strobe_o(unit_strobe_o),
    .unit_Quo_i(unit_Quo_i), .unit_Rem_i(unit_Rem_i),
    .unit_done_i(unit_done_i), .unit_ready_i(unit_ready_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_Quo_o(rsp_Quo_o), .rsp_Rem_o(rsp_Rem_o), .rsp_id_o(rsp_id_o),
    .busy_o(busy_o)
  );
  function automatic logic [2*W-1:0] ref_res(input logic [W-1:0] n, input logic [W-1:0] d, input logic dv);
    longint r;
    if (dv) begin
      if (d == 0) return {{W{1'b1}}, n};
      return {n / d, n % d};
    end
    r = 0;
    while ((r + 1) * (r + 1) <= longint'(n)) r++;
    return {W'(r), W'(longint'(n) - r * r)};
  endfunction
  function automatic int rr_next(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction
  always_comb begin
    req_N_i = '0;
    req_D_i = '0;
    req_is_div_i = '0;
    for (int i = 0; i < N; i++) begin
      req_N_i[i*W +: W] = n_arr[i];
      req_D_i[i*W +: W] = d_arr[i];
      req_is_div_i[i] = div_arr[i];
    end
  end
  always @(posedge clk) begin
    if (reset) begin
      u_busy <= 1'b0;
      u_cnt <= 0;
    end else if (u_busy) begin
      if (u_cnt == 0) u_busy <= 1'b0;
      else u_cnt <= u_cnt - 1;
    end else if (unit_strobe_o) begin
      u_busy <= 1'b1;
      u_cnt <= L - 1;
      {u_q, u_r} <= ref_res(unit_N_o, unit_D_o, unit_is_div_o);
    end
  end
  assign unit_done_i = u_busy && u_cnt == 0;
  assign unit_Quo_i = u_q;
  assign unit_Rem_i = u_r;
  assign unit_ready_i = !u_busy && force_rdy;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = '0;
    flush_i = 1'b0;
    force_rdy = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    last_g = N - 1;
    #1;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_req_ready"}, req_ready_o, 0);
    chk({tag, "_strobe"}, unit_strobe_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_quo"}, rsp_Quo_o, 0);
    chk({tag, "_rem"}, rsp_Rem_o, 0);
    chk({tag, "_id"}, rsp_id_o, 0);
    chk({tag, "_unit_n"}, unit_N_o, 0);
    chk({tag, "_unit_d"}, unit_D_o, 0);
    chk({tag, "_unit_div"}, unit_is_div_o, 0);
  endtask
  task automatic serve(input int hold, output int g);
    int c, eg;
    logic [N-1:0] oh;
    logic [2*W-1:0] e;
    eg = rr_next(req_valid_i, last_g);
    #1;
    c = 0;
    while (req_ready_o == 0 && c < 60) begin
      tick;
      c++;
    end
    g = 0;
    for (int i = 0; i < N; i++) if (req_ready_o[i]) g = i;
    oh = N'(1) << eg;
    chk("grant", req_ready_o, oh);
    e = ref_res(n_arr[g], d_arr[g], div_arr[g]);
    last_g = g;
    tick;
    chk("strobe_on", unit_strobe_o, 1);
    chk("unit_n", unit_N_o, n_arr[g]);
    chk("unit_d", unit_D_o, d_arr[g]);
    chk("unit_div", unit_is_div_o, div_arr[g]);
    tick;
    chk("strobe_off", unit_strobe_o, 0);
    c = 0;
    while (rsp_valid_o == 0 && c < 40) begin
      tick;
      c++;
    end
    chk("latency", c, L);
    oh = N'(1) << g;
    chk("rsp_valid", rsp_valid_o, oh);
    chk("rsp_id", rsp_id_o, g);
    chk("rsp_quo", rsp_Quo_o, e[2*W-1:W]);
    chk("rsp_rem", rsp_Rem_o, e[W-1:0]);
    repeat (hold) begin
      rsp_ready_i = ~oh;
      tick;
      chk("hold_valid", rsp_valid_o, oh);
      chk("hold_quo", rsp_Quo_o, e[2*W-1:W]);
      chk("hold_rem", rsp_Rem_o, e[W-1:0]);
      chk("hold_req_ready", req_ready_o, 0);
    end
    rsp_ready_i = '1;
    #1;
    chk("resp_done_no_grant", req_ready_o, 0);
    tick;
    rsp_ready_i = '0;
    chk("resp_idle_busy", busy_o, 0);
    chk("resp_idle_valid", rsp_valid_o, 0);
  endtask
  initial begin
    int g, c;
    logic seen;
    for (int i = 0; i < N; i++) begin
      n_arr[i] = '0;
      d_arr[i] = '0;
      div_arr[i] = 1'b0;
    end
    do_reset;
    chk_reset_vals("rst0");
    n_arr[0] = 26'h0800000;
    d_arr[0] = 26'h0400000;
    div_arr[0] = 1'b1;
    req_valid_i = 2'b01;
    serve(5, g);
    chk("div_quo_const", rsp_Quo_o, 2);
    chk("div_rem_const", rsp_Rem_o, 0);
    do_reset;
    for (int i = 0; i < N; i++) begin
      n_arr[i] = W'($urandom);
      d_arr[i] = W'($urandom_range(1, 4095));
      div_arr[i] = 1'($urandom_range(0, 1));
    end
    req_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      serve(k, g);
      chk("order", g, k % 2);
      n_arr[g] = W'($urandom);
      div_arr[g] = 1'($urandom_range(0, 1));
    end
    do_reset;
    n_arr[0] = W'($urandom);
    d_arr[0] = W'($urandom_range(1, 999));
    div_arr[0] = 1'b1;
    req_valid_i = 2'b01;
    #1;
    chk("fl_grant", req_ready_o, 2'b01);
    last_g = 0;
    tick;
    req_valid_i = '0;
    repeat (3) tick;
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    #1;
    chk("fl_idle", busy_o, 0);
    chk("fl_no_rsp", rsp_valid_o, 0);
    n_arr[1] = W'($urandom);
    d_arr[1] = W'($urandom_range(1, 999));
    div_arr[1] = 1'b0;
    req_valid_i = 2'b11;
    #1;
    c = 0;
    while (!unit_ready_i && c < 40) begin
      chk("fl_wait_no_grant", req_ready_o, 0);
      chk("fl_wait_no_rsp", rsp_valid_o, 0);
      tick;
      c++;
    end
    serve(1, g);
    chk("fl_next_g", g, 1);
    do_reset;
    force_rdy = 1'b0;
    req_valid_i = 2'b11;
    #1;
    repeat (4) begin
      chk("nordy_no_grant", req_ready_o, 0);
      tick;
    end
    force_rdy = 1'b1;
    flush_i = 1'b1;
    #1;
    chk("flush_wins", req_ready_o, 0);
    tick;
    flush_i = 1'b0;
    chk("flush_wins_idle", busy_o, 0);
    serve(0, g);
    chk("nordy_g", g, 0);
    do_reset;
    req_valid_i = 2'b01;
    #1;
    chk("rb_grant", req_ready_o, 2'b01);
    tick;
    req_valid_i = '0;
    repeat (3) tick;
    chk("rb_busy", busy_o, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_reset_vals("rst_busy");
    seen = 1'b0;
    repeat (20) begin
      tick;
      if (rsp_valid_o != 0 || busy_o) seen = 1'b1;
    end
    chk("rst_busy_no_rsp", seen, 0);
    do_reset;
    repeat (12) begin
      for (int i = 0; i < N; i++) begin
        n_arr[i] = W'($urandom);
        d_arr[i] = $urandom_range(0, 1) ? W'($urandom_range(1, 4095)) : W'($urandom_range(1, 1 << 20));
        div_arr[i] = 1'($urandom_range(0, 1));
      end
      req_valid_i = N'($urandom_range(1, 3));
      serve($urandom_range(0, 3), g);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/r5fp_divsqrt_arb.md
R5FP_DIVSQRT_ARB -- requirements
Module: r5fp_divsqrt_arb

Interface
REQ-001 Parameter W, default 26, SHALL be the operand width of the shared integer divide/sqrt unit.
REQ-002 Parameter N_REQ, default 2, SHALL be the number of requesters (2..8); IDW = max(1, clog2(N_REQ)).
REQ-003 Reset is named reset and is synchronous and active-high; the clock is named clk.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid_i  in  N_REQ  per-requester request valid
- req_ready_o  out  N_REQ  per-requester accept, one-hot or zero
- req_N_i  in  N_REQ*W  dividend/radicand, slice i per requester
- req_D_i  in  N_REQ*W  divisor, slice i per requester
- req_is_div_i  in  N_REQ  1=divide, 0=sqrt
- flush_i  in  1  abandon current operation
- unit_N_o  out  W  to unit N_i
- unit_D_o  out  W  to unit D_i
- unit_is_div_o  out  1  to unit is_div_i
- unit_strobe_o  out  1  one-cycle start pulse
- unit_Quo_i  in  W  unit quotient/root
- unit_Rem_i  in  W  unit remainder
- unit_done_i  in  1  unit result valid pulse
- unit_ready_i  in  1  unit idle
- rsp_valid_o  out  N_REQ  one-hot response valid
- rsp_ready_i  in  N_REQ  per-requester response accept
- rsp_Quo_o  out  W  held quotient
- rsp_Rem_o  out  W  held remainder
- rsp_id_o  out  IDW  owner of held result
- busy_o  out  1  state != IDLE

Function
REQ-005 The FSM SHALL have four states: IDLE, ISSUE, BUSY, RESP.
REQ-006 In IDLE with unit_ready_i=1 and any req_valid_i set, the arbiter SHALL grant one requester by round-robin, starting from the index after the last grant.
REQ-007 On a grant, req_ready_o[g]=1 combinationally in that cycle; the block SHALL register N, D, is_div and g, and go to ISSUE.
REQ-008 In IDLE with unit_ready_i=0, req_ready_o SHALL be all zero and no grant SHALL occur.
REQ-009 ISSUE SHALL drive unit_strobe_o=1 for exactly one cycle with the registered operands, then go to BUSY.
REQ-010 unit_N_o, unit_D_o and unit_is_div_o SHALL stay stable from ISSUE until the next grant.
REQ-011 In BUSY, on unit_done_i=1 the block SHALL capture unit_Quo_i and unit_Rem_i into rsp_Quo_o and rsp_Rem_o, and go to RESP.
REQ-012 unit_done_i SHALL be ignored in every state other than BUSY.
REQ-013 In RESP, rsp_valid_o SHALL be one-hot at rsp_id_o, and rsp_Quo_o, rsp_Rem_o and rsp_id_o SHALL be held stable.
REQ-014 In RESP, when rsp_ready_i[rsp_id_o]=1 the block SHALL return to IDLE; rsp_ready_i bits of other requesters SHALL be ignored.
REQ-015 No new grant SHALL occur in the cycle RESP completes; the earliest next grant is the following cycle.
REQ-016 Latency: accept at cycle t, strobe at t+1, unit done at t+1+L, rsp_valid at t+2+L.
REQ-017 flush_i=1 in any state SHALL force IDLE next cycle, clear rsp_valid_o and discard any later unit_done_i of the abandoned operation.
REQ-018 If flush_i=1 coincides with a grant condition, flush SHALL win: req_ready_o all zero and no grant.
REQ-019 The round-robin pointer SHALL update only on a grant, to the granted index, and SHALL wrap from N_REQ-1 to 0.

Reset
REQ-020 On reset the block SHALL be in IDLE with the RR pointer = N_REQ-1, so requester 0 wins first.
REQ-021 On reset, rsp_valid_o, req_ready_o, unit_strobe_o and busy_o SHALL be 0.
REQ-022 On reset, rsp_Quo_o, rsp_Rem_o, rsp_id_o, unit_N_o, unit_D_o and unit_is_div_o SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL abort at the next edge with no response issued; the unit is expected to be reset by the same reset.

Structure
REQ-024 The state enum and the state encoding SHALL be in a shared package r5fp_arb_pkg.
REQ-025 The round-robin grant logic SHALL be one sub-module, r5fp_rr_arb (inputs: request vector, pointer; output: one-hot grant and index).
REQ-026 The block SHALL instantiate neither the divide/sqrt unit nor any FP pre/post-processing.

Verification
REQ-027 The bench SHALL use a behavioural unit model with latency L=14; the checks are:
- Single div: req0 N=0x0800000, D=0x0400000 -> one strobe at t+1, rsp_valid_o=01 at t+16, Quo/Rem equal to the model output.
- Both requesting after reset: grants in order 0,1,0,1 across four operations.
- rsp_ready_i held low 5 cycles in RESP: rsp_valid_o stays set, Quo/Rem stable, req_ready_o=00.
- flush_i at BUSY cycle 3: IDLE next cycle, no rsp_valid_o; while unit_ready_i=0 no grant; after unit_done_i the next grant returns the new result.
- unit_ready_i=0 in IDLE with req_valid_i=11: req_ready_o=00 until unit_ready_i rises.
- reset asserted during BUSY: all outputs return to reset values next cycle, no response.
